// File: rtl/code_display_pkg.sv
// Shared types and constants for the code display stage.
package code_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 7;
  localparam logic [2:0] MAX_COUNT = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY      = 2'd1,
    ST_RESULT_OK  = 2'd2,
    ST_RESULT_ERR = 2'd3
  } state_e;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g
  localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [DIGIT_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [DIGIT_W-1:0] SEG_P     = 7'h0C;
  localparam logic [DIGIT_W-1:0] SEG_A     = 7'h08;
  localparam logic [DIGIT_W-1:0] SEG_S     = 7'h12;
  localparam logic [DIGIT_W-1:0] SEG_E     = 7'h06;
  localparam logic [DIGIT_W-1:0] SEG_R     = 7'h2F;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_7seg
  import code_display_pkg::*;
(
  input  logic [3:0]         hex_i,
  output logic [DIGIT_W-1:0] seg_o
);

  // Lookup of the glyph for each nibble value
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/code_display_sm.sv
// Display stage for the 4-digit code entry bank.
// Shows entered digits right-justified, then PASS or a blinking Err for a
// hold period. Build option MASK_DIGITS_EN replaces entered digits with '-'.
module code_display_sm
  import code_display_pkg::*;
#(
  parameter int BLINK_DIV   = 500,
  parameter int HOLD_CYCLES = 3000,
  parameter int CNT_W       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] code_in,
  input  logic        code_load,
  input  logic        code_clear,
  input  logic        result_err,
  input  logic        result_ok,
  output logic [27:0] seven_segment,
  output logic        busy
);

  state_e                                   state_q, state_d;
  logic [2:0]                               count_q, count_d;
  logic [CNT_W-1:0]                         cnt_q, cnt_d;
  logic                                     err_q, ok_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       seg_q, seg_d;
  logic                                     busy_q, busy_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]       hex_seg;
  logic [CNT_W-1:0]                         blink_idx;
  logic                                     err_rise, ok_rise, in_result;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    hex_to_7seg u_hex (
      .hex_i (code_in[4*g +: 4]),
      .seg_o (hex_seg[g])
    );
  end

  assign err_rise  = result_err & ~err_q;
  assign ok_rise   = result_ok  & ~ok_q;
  assign in_result = (state_q == ST_RESULT_OK) || (state_q == ST_RESULT_ERR);

  // Next state, digit count and hold counter; clear > result edge > load
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cnt_d   = '0;
    if (code_clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (err_rise) begin
      state_d = ST_RESULT_ERR;
    end else if (ok_rise) begin
      state_d = ST_RESULT_OK;
    end else if (code_load) begin
      state_d = ST_ENTRY;
      if (in_result)                count_d = 3'd1;
      else if (count_q < MAX_COUNT) count_d = count_q + 3'd1;
    end else if (in_result) begin
      if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Blink phase follows the counter value that will be displayed
  assign blink_idx = cnt_d / CNT_W'(BLINK_DIV);

  // Display pattern for the upcoming state; registered below
  always_comb begin
    seg_d  = {NUM_DIGITS{SEG_BLANK}};
    busy_d = 1'b0;
    case (state_d)
      ST_ENTRY: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (k < int'(count_d)) begin
`ifdef MASK_DIGITS_EN
            seg_d[k] = SEG_DASH;
`else
            seg_d[k] = hex_seg[k];
`endif
          end
        end
      end
      ST_RESULT_OK: begin
        busy_d = 1'b1;
        seg_d  = {SEG_P, SEG_A, SEG_S, SEG_S};
      end
      ST_RESULT_ERR: begin
        busy_d = 1'b1;
        if (!blink_idx[0]) seg_d = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      err_q   <= result_err;
      ok_q    <= result_ok;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
    end
  end

  assign seven_segment = seg_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_code_display_sm.sv
// Self-checking bench for code_display_sm with a behavioural display model.
module tb_code_display_sm;

  localparam int BLINK = 4;
  localparam int HOLD  = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] code_in = '0;
  logic        code_load = 1'b0, code_clear = 1'b0;
  logic        result_err = 1'b0, result_ok = 1'b0;
  logic [27:0] seven_segment;
  logic        busy;

  int total = 0;
  int bad   = 0;

  code_display_sm #(.BLINK_DIV(BLINK), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_load(code_load),
    .code_clear(code_clear), .result_err(result_err), .result_ok(result_ok),
    .seven_segment(seven_segment), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the panel should show, from the behaviour rules
  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  string      m_mode = "idle";
  int         m_n = 0, m_age = 0;
  bit         m_pe = 0, m_po = 0;
  logic [15:0] m_code = '0;

  task automatic model_reset();
    m_mode = "idle"; m_n = 0; m_age = 0; m_pe = 0; m_po = 0;
  endtask

  task automatic model_clk(bit ld, bit clr, bit er, bit ok, logic [15:0] code);
    bit re, ro;
    re = er && !m_pe; ro = ok && !m_po;
    m_pe = er; m_po = ok; m_code = code;
    if (clr) begin
      m_mode = "idle"; m_n = 0;
    end else if (re || ro) begin
      m_mode = re ? "err" : "ok"; m_age = 0;
    end else if (ld) begin
      if (m_mode == "ok" || m_mode == "err") m_n = 1;
      else m_n = (m_n + 1 > 4) ? 4 : m_n + 1;
      m_mode = "entry";
    end else if (m_mode == "ok" || m_mode == "err") begin
      m_age++;
      if (m_age >= HOLD) begin m_mode = "idle"; m_n = 0; end
    end
  endtask

  function automatic logic [27:0] model_seg();
    logic [6:0] d [4];
    for (int k = 0; k < 4; k++) d[k] = 7'h7F;
    if (m_mode == "entry") begin
      for (int k = 0; k < m_n; k++) begin
`ifdef MASK_DIGITS_EN
        d[k] = 7'h3F;
`else
        d[k] = hex7[m_code[4*k +: 4]];
`endif
      end
    end else if (m_mode == "ok") begin
      d[3] = 7'h0C; d[2] = 7'h08; d[1] = 7'h12; d[0] = 7'h12;
    end else if (m_mode == "err" && ((m_age / BLINK) % 2) == 0) begin
      d[3] = 7'h06; d[2] = 7'h2F; d[1] = 7'h2F;
    end
    return {d[3], d[2], d[1], d[0]};
  endfunction

  function automatic bit model_busy();
    return (m_mode == "ok" || m_mode == "err");
  endfunction

  task automatic chk(string tag, logic [27:0] seg_exp, logic busy_exp);
    total++;
    assert (seven_segment === seg_exp) else begin
      bad++;
      $error("FAIL %s seg got %h want %h", tag, seven_segment, seg_exp);
    end
    total++;
    assert (busy === busy_exp) else begin
      bad++;
      $error("FAIL %s busy got %b want %b", tag, busy, busy_exp);
    end
  endtask

  // Drive one cycle of inputs (called at negedge), clock it, check vs model
  task automatic step(string tag, bit ld, bit clr, bit er, bit ok, logic [15:0] code);
    code_load = ld; code_clear = clr; result_err = er; result_ok = ok; code_in = code;
    @(posedge clk);
    model_clk(ld, clr, er, ok, code);
    @(negedge clk);
    chk(tag, model_seg(), model_busy());
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("reset", 28'hFFFFFFF, 1'b0);
    rst = 1'b0;
    model_reset();

    // Entry, right-justified, saturating at four digits
    step("one", 1, 0, 0, 0, 16'h0001);
    chk("one_k", {7'h7F, 7'h7F, 7'h7F, 7'h79}, 1'b0);
    step("gap", 0, 0, 0, 0, 16'h0001);
    step("two", 1, 0, 0, 0, 16'h0012);
    step("thr", 1, 0, 0, 0, 16'h0123);
    step("four", 1, 0, 0, 0, 16'h1234);
    chk("four_k", {7'h79, 7'h24, 7'h30, 7'h19}, 1'b0);
    step("sat", 1, 0, 0, 0, 16'h2345);
    chk("sat_k", {7'h24, 7'h30, 7'h19, 7'h12}, 1'b0);

    // PASS after two digits, hold, then one digit
    step("clr", 0, 1, 0, 0, 16'h2345);
    step("d1", 1, 0, 0, 0, 16'h0005);
    step("d2", 1, 0, 0, 0, 16'h0056);
    step("pass", 0, 0, 0, 1, 16'h0056);
    chk("pass_k", {7'h0C, 7'h08, 7'h12, 7'h12}, 1'b1);
    for (int i = 0; i < HOLD - 1; i++) step("hold", 0, 0, 0, 1, 16'h0056);
    chk("hold_k", {7'h0C, 7'h08, 7'h12, 7'h12}, 1'b1);
    step("expire", 0, 0, 0, 1, 16'h0056);
    chk("expire_k", 28'hFFFFFFF, 1'b0);
    step("after", 1, 0, 0, 0, 16'h0005);
    chk("after_k", {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b0);

    // Blinking Err, then a load aborts it
    step("err", 0, 0, 1, 0, 16'h0005);
    chk("err_k", {7'h06, 7'h2F, 7'h2F, 7'h7F}, 1'b1);
    for (int i = 0; i < BLINK - 1; i++) step("errhold", 0, 0, 1, 0, 16'h0005);
    step("blankph", 0, 0, 1, 0, 16'h0005);
    chk("blank_k", 28'hFFFFFFF, 1'b1);
    for (int i = 0; i < BLINK; i++) step("blinkb", 0, 0, 1, 0, 16'h0005);
    chk("reblink_k", {7'h06, 7'h2F, 7'h2F, 7'h7F}, 1'b1);
    step("abort", 1, 0, 1, 0, 16'h0007);
    chk("abort_k", {7'h7F, 7'h7F, 7'h7F, 7'h78}, 1'b0);

    // Simultaneous rise: err wins
    step("drop", 0, 0, 0, 0, 16'h0007);
    step("both", 0, 0, 1, 1, 16'h0007);
    chk("both_k", {7'h06, 7'h2F, 7'h2F, 7'h7F}, 1'b1);

    // Clear beats both a result edge and a load
    step("drop2", 0, 0, 0, 0, 16'h0007);
    step("clrall", 1, 1, 1, 0, 16'h0007);
    chk("clrall_k", 28'hFFFFFFF, 1'b0);

    // Three digits of 0789
    step("m1", 1, 0, 1, 0, 16'h0789);
    step("m2", 1, 0, 1, 0, 16'h0789);
    step("m3", 1, 0, 1, 0, 16'h0789);
`ifdef MASK_DIGITS_EN
    chk("mask_k", {7'h7F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);
`else
    chk("hex3_k", {7'h7F, 7'h78, 7'h00, 7'h10}, 1'b0);
`endif

    // Asynchronous reset in the middle of a result
    step("drop3", 0, 0, 0, 0, 16'h0789);
    step("err2", 0, 0, 1, 0, 16'h0789);
    step("err2b", 0, 0, 1, 0, 16'h0789);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk("async_rst", 28'hFFFFFFF, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("post_rst", 28'hFFFFFFF, 1'b0);

    // Random traffic against the model
    begin
      bit er = 0, ok = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 99) < 6) er = ~er;
        if ($urandom_range(0, 99) < 6) ok = ~ok;
        step("rand", $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
             er, ok, 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
